// File: rtl/width_conv_fifo_if.sv
// Handshake/status bundle for width_conv_fifo. With WCFIFO_ERR_EN defined the
// sticky overflow/underflow flags are carried as well.
interface width_conv_fifo_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             input_valid;
  logic             output_enable;
  logic [IN_W-1:0]  data_in;
  logic [OUT_W-1:0] data_out;
  logic             output_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      level;
`ifdef WCFIFO_ERR_EN
  logic             overflow;
  logic             underflow;

  modport master (
    output input_valid, output_enable, data_in,
    input  data_out, output_valid, full, empty, level, overflow, underflow
  );
  modport slave (
    input  input_valid, output_enable, data_in,
    output data_out, output_valid, full, empty, level, overflow, underflow
  );
`else
  modport master (
    output input_valid, output_enable, data_in,
    input  data_out, output_valid, full, empty, level
  );
  modport slave (
    input  input_valid, output_enable, data_in,
    output data_out, output_valid, full, empty, level
  );
`endif
endinterface

// File: rtl/width_conv_fifo.sv
// Synchronous FIFO taking IN_W-bit words and returning OUT_W-bit slices, LS slice first.
// Optional sticky overflow/underflow flags are built when WCFIFO_ERR_EN is defined.
module width_conv_fifo #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              rstn,
  width_conv_fifo_if.slave bus
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] SIDX_LAST = SW'(RATIO - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  logic [IN_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]    sidx_q, sidx_d;
  logic [LW-1:0]    level_q, level_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             oval_q, oval_d;

  logic             full, empty;
  logic             wr_en, rd_en, rd_free;
  logic [IN_W-1:0]  rd_word;
  logic [OUT_W-1:0] rd_slice;

  // Status comes from the registered level, so a freeing read never unblocks a same-cycle write.
  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign wr_en   = bus.input_valid && !full;
  assign rd_en   = bus.output_enable && !empty;
  assign rd_free = rd_en && (sidx_q == SIDX_LAST);

  assign rd_word  = mem[rd_ptr_q];
  assign rd_slice = rd_word[sidx_q*OUT_W +: OUT_W];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sidx_d   = sidx_q;
    level_d  = level_q;
    dout_d   = dout_q;
    oval_d   = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_en) begin
      dout_d = rd_slice;
      oval_d = 1'b1;
      if (rd_free) begin
        sidx_d   = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        sidx_d = sidx_q + 1'b1;
      end
    end

    case ({wr_en, rd_free})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sidx_q   <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      oval_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sidx_q   <= sidx_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      oval_q   <= oval_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.output_valid = oval_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = level_q;

`ifdef WCFIFO_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.input_valid && full)    ovf_q <= 1'b1;
      if (bus.output_enable && empty) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif
endmodule
